aes_enc_round_sequencer: RTL and testbench

Iterative AES encryption controller that sequences a single combinational full-round datapath over NUM_ROUNDS rounds, one round per clock. It accepts one 128-bit block at a time over a valid/ready handshake. Round keys come from external key storage through an index/data port, and the ciphertext is presented over a valid/ready output handshake. It sits between the XTS tweak/data path and the precomputed round-key store.

---
 rtl/aes_seq_pkg.sv | 79 +++++++
 rtl/aes_enc_round_sequencer_final.sv | 12 +
 rtl/aes_enc_round_sequencer.sv | 108 ++++++++++
 tb/tb_aes_enc_round_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_seq_pkg.sv
// Shared definitions for the iterative AES encryption sequencer: state encoding,
// round-count constants and the byte-level round primitives.
package aes_seq_pkg;

    localparam int RK_IDX_W      = 4;
    localparam int AES128_ROUNDS = 10;
    localparam int AES192_ROUNDS = 12;
    localparam int AES256_ROUNDS = 14;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd1;
    localparam logic [2:0] ST_FIN1 = 3'd2;
    localparam logic [2:0] ST_FIN2 = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_FIN1 = ST_FIN1,
        S_FIN2 = ST_FIN2,
        S_DONE = ST_DONE
    } seq_state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Byte i of the 128-bit state sits at [127-8i -: 8]; AES state is column-major.
    function automatic logic [127:0] aes_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++)
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] aes_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] aes_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
            o[103-32*c -: 8] = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
        end
        return o;
    endfunction

    // Key is added first, so round 0 of the sequencer also absorbs the initial AddRoundKey.
    function automatic logic [127:0] aes_full_round(input logic [127:0] s, input logic [127:0] k);
        return aes_mix_columns(aes_shift_rows(aes_sub_bytes(s ^ k)));
    endfunction

endpackage

// File: rtl/aes_enc_round_sequencer_final.sv
// Final-round datapath: AddRoundKey, SubBytes, ShiftRows with no MixColumns.
module aes_final_round_fun
    import aes_seq_pkg::*;
(
    input  logic [127:0] st,
    input  logic [127:0] rk,
    output logic [127:0] res
);

    assign res = aes_shift_rows(aes_sub_bytes(st ^ rk));

endmodule

// File: rtl/aes_enc_round_sequencer.sv
// Iterative AES encryption sequencer, one round per clock over an external round-key port.
// Optional feature: define AES_SEQ_ABORT_EN to add the inAbort port.
module aes_enc_round_sequencer
    import aes_seq_pkg::*;
#(
    parameter int NUM_ROUNDS = AES256_ROUNDS,
    parameter int RK_IDX_W   = aes_seq_pkg::RK_IDX_W
) (
    input  logic                clk,
    input  logic                rstN,
`ifdef AES_SEQ_ABORT_EN
    input  logic                inAbort,
`endif
    input  logic                inValid,
    output logic                inReady,
    input  logic [127:0]        inData,
    output logic [RK_IDX_W-1:0] outRkIdx,
    input  logic [127:0]        inRoundKey,
    output logic                outValid,
    input  logic                outReady,
    output logic [127:0]        outData,
    output logic                outBusy
);

    localparam logic [RK_IDX_W-1:0] RND_LAST   = RK_IDX_W'(NUM_ROUNDS - 2);
    localparam logic [RK_IDX_W-1:0] IDX_FIN1   = RK_IDX_W'(NUM_ROUNDS - 1);
    localparam logic [RK_IDX_W-1:0] IDX_FIN2   = RK_IDX_W'(NUM_ROUNDS);

    seq_state_t          state;
    logic [RK_IDX_W-1:0] rnd;
    logic [127:0]        st_reg;
    logic [127:0]        full_nxt;
    logic [127:0]        fin_nxt;
    logic                abort;

`ifdef AES_SEQ_ABORT_EN
    assign abort = inAbort;
`else
    assign abort = 1'b0;
`endif

    assign full_nxt = aes_full_round(st_reg, inRoundKey);

    aes_final_round_fun u_fin (
        .st  (st_reg),
        .rk  (inRoundKey),
        .res (fin_nxt)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state  <= S_IDLE;
            st_reg <= '0;
            rnd    <= '0;
        end else if (abort && state != S_IDLE) begin
            // Abort wins over any in-flight work; a DONE transfer in the same cycle still completes.
            state  <= S_IDLE;
            st_reg <= '0;
            rnd    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (inValid) begin
                        st_reg <= inData;
                        rnd    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    st_reg <= full_nxt;
                    rnd    <= rnd + RK_IDX_W'(1);
                    if (rnd == RND_LAST)
                        state <= S_FIN1;
                end
                S_FIN1: begin
                    st_reg <= fin_nxt;
                    state  <= S_FIN2;
                end
                S_FIN2: begin
                    st_reg <= st_reg ^ inRoundKey;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    if (outReady)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Key index is decoded purely from registered state so the key store sees a clean address.
    always_comb begin
        outRkIdx = '0;
        case (state)
            S_RUN:   outRkIdx = rnd;
            S_FIN1:  outRkIdx = IDX_FIN1;
            S_FIN2:  outRkIdx = IDX_FIN2;
            default: outRkIdx = '0;
        endcase
    end

    assign inReady  = (state == S_IDLE);
    assign outValid = (state == S_DONE);
    assign outBusy  = (state != S_IDLE);
    assign outData  = st_reg;

endmodule

// File: tb/tb_aes_enc_round_sequencer.sv
// Directed bench for aes_enc_round_sequencer (AES-256 and AES-128 instances) with a ciphertext scoreboard.
module tb_aes_enc_round_sequencer;

    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk;
    logic         rst_n;
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_out_data, a_rk;
    logic [3:0]   a_rk_idx;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
    logic [127:0] b_in_data, b_out_data, b_rk;
    logic [3:0]   b_rk_idx;
`ifdef AES_SEQ_ABORT_EN
    logic         a_abort, b_abort;
`endif

    logic [127:0] rk256 [0:15];
    logic [127:0] rk128 [0:15];
    logic [31:0]  w [0:59];
    logic [7:0]   sbx [0:255];
    logic [127:0] exp_q [$];
    int           n_assert = 0;
    int           n_fail   = 0;
    int           cyc      = 0;

    assign a_rk = rk256[a_rk_idx];
    assign b_rk = rk128[b_rk_idx];

    aes_enc_round_sequencer #(.NUM_ROUNDS(14), .RK_IDX_W(4)) dut_a (
        .clk(clk), .rstN(rst_n),
`ifdef AES_SEQ_ABORT_EN
        .inAbort(a_abort),
`endif
        .inValid(a_in_valid), .inReady(a_in_ready), .inData(a_in_data),
        .outRkIdx(a_rk_idx), .inRoundKey(a_rk), .outValid(a_out_valid),
        .outReady(a_out_ready), .outData(a_out_data), .outBusy(a_busy)
    );

    aes_enc_round_sequencer #(.NUM_ROUNDS(10), .RK_IDX_W(4)) dut_b (
        .clk(clk), .rstN(rst_n),
`ifdef AES_SEQ_ABORT_EN
        .inAbort(b_abort),
`endif
        .inValid(b_in_valid), .inReady(b_in_ready), .inData(b_in_data),
        .outRkIdx(b_rk_idx), .inRoundKey(b_rk), .outValid(b_out_valid),
        .outReady(b_out_ready), .outData(b_out_data), .outBusy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bxt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = bxt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box derived from the GF(2^8) inverse plus affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbx[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] v);
        return {sbx[v[31:24]], sbx[v[23:16]], sbx[v[15:8]], sbx[v[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nk + 7); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = bxt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
    endtask

    function automatic logic [127:0] round_key(input int nr, input int r);
        return (nr == 14) ? rk256[r] : rk128[r];
    endfunction

    // Textbook-order reference encryption on a byte array.
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] k, res;
        k = round_key(nr, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbx[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    s[row+4*col] = t[row+4*((col+row)%4)];
            if (r != nr) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                    s[4*col]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*col+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            k = round_key(nr, r);
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        res = '0;
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard side: every completed AES-256 transfer pops one expected ciphertext.
    always @(negedge clk) begin
        #1;
        if (rst_n && a_out_valid && a_out_ready) begin
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed output %h, expected no output", a_out_data);
            end
            if (exp_q.size() != 0) chk("ct_scoreboard", a_out_data, exp_q.pop_front());
        end
    end

    initial begin
        logic [127:0] p;
        int           nacc, found;
        int           acc_cyc [2];

        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
        a_abort = 1'b0; b_abort = 1'b0;
`endif
        for (int i = 0; i < 16; i++) begin
            rk256[i] = '0;
            rk128[i] = '0;
        end
        build_sbox();
        expand(KEY256, 8);
        for (int r = 0; r < 15; r++) rk256[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        expand({KEY128, 128'h0}, 4);
        for (int r = 0; r < 11; r++) rk128[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};

        // Reset state
        repeat (2) @(negedge clk);
        chkb("rst_inready", a_in_ready, 1'b1);
        chkb("rst_outvalid", a_out_valid, 1'b0);
        chk("rst_outdata", a_out_data, '0);
        chk("rst_rkidx", 128'(a_rk_idx), 128'd0);
        chkb("rst_busy", a_busy, 1'b0);
        chkb("rst128_inready", b_in_ready, 1'b1);
        chkb("rst128_outvalid", b_out_valid, 1'b0);
        rst_n = 1'b1;

        // FIPS-197 AES-256 block: key index sequence, latency, then backpressure
        @(negedge clk);
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = PT;
        exp_q.push_back(model_enc(PT, 14));
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int j = 0; j <= 15; j++) begin
            chk("rkidx_seq", 128'(a_rk_idx), 128'((j <= 14) ? j : 0));
            chkb("latency256_valid", a_out_valid, (j == 15));
            if (j < 15) @(negedge clk);
        end
        for (int j = 0; j < 20; j++) begin
            chk("bp_data", a_out_data, CT256);
            chkb("bp_valid", a_out_valid, 1'b1);
            chkb("bp_inready", a_in_ready, 1'b0);
            @(negedge clk);
        end
        a_out_ready = 1'b1;
        @(negedge clk);
        chkb("after_xfer_valid", a_out_valid, 1'b0);
        chkb("after_xfer_inready", a_in_ready, 1'b1);

        // Back-to-back with inValid held high
        a_in_valid = 1'b1;
        a_in_data  = rand128();
        nacc = 0;
        for (int k = 0; k < 100 && nacc < 2; k++) begin
            if (a_in_valid && a_in_ready) begin
                acc_cyc[nacc] = cyc;
                exp_q.push_back(model_enc(a_in_data, 14));
                nacc++;
                @(negedge clk);
                if (nacc == 1) a_in_data = rand128();
                else a_in_valid = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        a_in_valid = 1'b0;
        chki("b2b_accepts", nacc, 2);
        if (nacc == 2) chki("b2b_gap", acc_cyc[1] - acc_cyc[0], 17);
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        chki("b2b_drain", exp_q.size(), 0);

        // Reset asserted mid-block at rnd 7
        a_in_valid = 1'b1;
        a_in_data  = rand128();
        @(negedge clk);
        a_in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (a_busy && a_rk_idx == 4'd7) found = 1;
            else @(negedge clk);
        end
        chki("rnd7_reached", found, 1);
        rst_n = 1'b0;
        #1;
        chkb("midrst_inready", a_in_ready, 1'b1);
        chkb("midrst_outvalid", a_out_valid, 1'b0);
        chk("midrst_outdata", a_out_data, '0);
        chk("midrst_rkidx", 128'(a_rk_idx), 128'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        p = rand128();
        a_in_valid = 1'b1;
        a_in_data  = p;
        exp_q.push_back(model_enc(p, 14));
        @(negedge clk);
        a_in_valid = 1'b0;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) @(negedge clk);
        chki("postrst_drain", exp_q.size(), 0);

`ifdef AES_SEQ_ABORT_EN
        // Abort at rnd 5: back to IDLE with cleared state, no output
        a_in_valid = 1'b1;
        a_in_data  = rand128();
        @(negedge clk);
        a_in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (a_busy && a_rk_idx == 4'd5) found = 1;
            else @(negedge clk);
        end
        chki("rnd5_reached", found, 1);
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chkb("abort_busy", a_busy, 1'b0);
        chkb("abort_inready", a_in_ready, 1'b1);
        chkb("abort_outvalid", a_out_valid, 1'b0);
        chk("abort_outdata", a_out_data, '0);
        repeat (20) @(negedge clk);
        chkb("abort_still_idle", a_out_valid, 1'b0);
`endif

        // AES-128 instance: FIPS vector and latency 11
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = PT;
        @(negedge clk);
        b_in_valid = 1'b0;
        for (int j = 0; j <= 11; j++) begin
            chkb("latency128_valid", b_out_valid, (j == 11));
            if (j < 11) @(negedge clk);
        end
        chk("ct128_fips", b_out_data, CT128);
        @(negedge clk);
        chkb("ct128_done", b_out_valid, 1'b0);
        p = rand128();
        b_in_valid = 1'b1;
        b_in_data  = p;
        @(negedge clk);
        b_in_valid = 1'b0;
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            if (b_out_valid) found = 1;
            else @(negedge clk);
        end
        chki("ct128_rand_seen", found, 1);
        chk("ct128_rand", b_out_data, model_enc(p, 10));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
